// File: rtl/branch_flag_unit.sv
// Branch/flag unit: latches comparator results into ZF/SF, tracks an outstanding
// compare, resolves conditional branches against the registered flags, owns the PC
// and drives a fixed-length flush after every taken branch.
module branch_flag_unit #(
  parameter int unsigned       ADDR_W       = 20,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_issue,
  input  logic              cmp_valid,
  input  logic [1:0]        cmp_kind,
  input  logic              cmp_flag,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              flush,
  output logic              zf,
  output logic              sf
);

  localparam int unsigned     CntW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitFlag,
    StResolve,
    StFlush
  } state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              zf_q, zf_d;
  logic              sf_q, sf_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              taken_q, taken_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              cond_true;

  assign accept = br_valid & ready_q;

  // Flag writes and outstanding-compare tracking; a new issue wins over a completion.
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    if (cmp_valid) begin
      unique case (cmp_kind)
        2'b00:        zf_d = cmp_flag;
        2'b01, 2'b10: sf_d = cmp_flag;
        default:      ;  // reserved kind: no flag write
      endcase
    end
    if (cmp_issue) begin
      pending_d = 1'b1;
    end else if (cmp_valid) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Branch condition, evaluated on the registered flags only.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond_q)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = zf_q;
      3'b010:  cond_true = ~zf_q;
      3'b011:  cond_true = sf_q;
      3'b100:  cond_true = ~sf_q;
      default: cond_true = 1'b0;
    endcase
  end

  // Branch FSM next state, PC update and taken pulse.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cond_d   = cond_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    taken_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cond_d   = br_cond;
          target_d = br_target;
          state_d  = (pending_q || cmp_valid) ? StWaitFlag : StResolve;
        end else if (pc_inc) begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      StWaitFlag: begin
        // Flags are registered by the time RESOLVE evaluates them.
        if (!pending_d) begin
          state_d = StResolve;
        end
      end
      StResolve: begin
        if (cond_true) begin
          pc_d    = target_q;
          taken_d = 1'b1;
          cnt_d   = '0;
          state_d = StFlush;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  // State registers; reset aborts any branch or flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      pc_q      <= RESET_PC;
      cond_q    <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      pc_q      <= pc_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      ready_q   <= ready_d;
    end
  end

  assign pc       = pc_q;
  assign taken    = taken_q;
  assign flush    = (state_q == StFlush);
  assign br_ready = ready_q;
  assign zf       = zf_q;
  assign sf       = sf_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit with hand-computed expectations.
module tb_branch_flag_unit;

  localparam int unsigned ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmp_issue, cmp_valid, cmp_flag;
  logic [1:0]        cmp_kind;
  logic              br_valid, br_ready;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic              taken, flush, zf, sf;

  int n_checks = 0;
  int n_fail   = 0;

  branch_flag_unit #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (20'h00000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmp_issue(cmp_issue),
    .cmp_valid(cmp_valid),
    .cmp_kind (cmp_kind),
    .cmp_flag (cmp_flag),
    .br_valid (br_valid),
    .br_ready (br_ready),
    .br_cond  (br_cond),
    .br_target(br_target),
    .pc_inc   (pc_inc),
    .pc       (pc),
    .taken    (taken),
    .flush    (flush),
    .zf       (zf),
    .sf       (sf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_pulse(input logic [1:0] kind, input logic flag);
    cmp_valid = 1'b1;
    cmp_kind  = kind;
    cmp_flag  = flag;
    cycle();
    cmp_valid = 1'b0;
  endtask

  // Taken branch with condition "always"; leaves the unit back in IDLE.
  task automatic jump(input logic [ADDR_W-1:0] tgt);
    br_valid  = 1'b1;
    br_cond   = 3'b000;
    br_target = tgt;
    cycle();
    br_valid = 1'b0;
    cycle();
    check_eq("jump_pc", 32'(pc), 32'(tgt));
    cycle();
    cycle();
    check_eq("jump_ready", 32'(br_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmp_issue = 1'b0; cmp_valid = 1'b0; cmp_kind = 2'b00; cmp_flag = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_target = '0; pc_inc = 1'b0;

    // Reset values
    #2;
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_zf", 32'(zf), 32'd0);
    check_eq("rst_sf", 32'(sf), 32'd0);
    check_eq("rst_taken", 32'(taken), 32'd0);
    check_eq("rst_flush", 32'(flush), 32'd0);
    check_eq("rst_ready", 32'(br_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(br_ready), 32'd0);
    cycle();
    check_eq("ready_first_edge", 32'(br_ready), 32'd1);
    check_eq("pc_after_rst", 32'(pc), 32'h0);

    // Sequential increment
    pc_inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check_eq("pc_inc_seq", 32'(pc), 32'(i));
    end
    pc_inc = 1'b0;

    // EQ flag=1 then branch on ZF=1
    cmp_pulse(2'b00, 1'b1);
    check_eq("zf_set", 32'(zf), 32'd1);
    br_valid = 1'b1; br_cond = 3'b001; br_target = 20'h00ABC;
    cycle();  // edge T
    br_valid = 1'b0; br_target = 20'h12345; br_cond = 3'b111;  // must be ignored
    check_eq("t1_ready", 32'(br_ready), 32'd0);
    check_eq("t1_pc", 32'(pc), 32'h3);
    cycle();
    check_eq("t2_pc", 32'(pc), 32'h00ABC);
    check_eq("t2_taken", 32'(taken), 32'd1);
    check_eq("t2_flush", 32'(flush), 32'd1);
    cycle();
    check_eq("t3_taken", 32'(taken), 32'd0);
    check_eq("t3_flush", 32'(flush), 32'd1);
    check_eq("t3_ready", 32'(br_ready), 32'd0);
    cycle();
    check_eq("t4_flush", 32'(flush), 32'd0);
    check_eq("t4_ready", 32'(br_ready), 32'd1);

    // SF via GT then LT, reserved kind writes nothing
    jump(20'h00010);
    cmp_pulse(2'b01, 1'b1);
    check_eq("sf_gt", 32'(sf), 32'd1);
    cmp_pulse(2'b10, 1'b0);
    check_eq("sf_lt", 32'(sf), 32'd0);
    cmp_pulse(2'b11, 1'b1);
    check_eq("kind11_zf", 32'(zf), 32'd1);
    check_eq("kind11_sf", 32'(sf), 32'd0);

    // Not-taken branch on SF=1
    br_valid = 1'b1; br_cond = 3'b011; br_target = 20'h00055;
    cycle();
    br_valid = 1'b0;
    check_eq("nt_t1_flush", 32'(flush), 32'd0);
    cycle();
    check_eq("nt_pc", 32'(pc), 32'h00011);
    check_eq("nt_taken", 32'(taken), 32'd0);
    check_eq("nt_flush", 32'(flush), 32'd0);
    check_eq("nt_ready", 32'(br_ready), 32'd1);

    // Branch waits on a pending compare (ZF=0 condition)
    cmp_issue = 1'b1;
    cycle();
    cmp_issue = 1'b0;
    br_valid = 1'b1; br_cond = 3'b010; br_target = 20'h00200;
    cycle();  // edge T
    br_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("wait_ready", 32'(br_ready), 32'd0);
      check_eq("wait_pc", 32'(pc), 32'h00011);
      check_eq("wait_taken", 32'(taken), 32'd0);
    end
    cmp_pulse(2'b00, 1'b0);  // edge U = T+3
    check_eq("u_zf", 32'(zf), 32'd0);
    check_eq("u_taken", 32'(taken), 32'd0);
    check_eq("u_pc", 32'(pc), 32'h00011);
    cycle();
    check_eq("u2_pc", 32'(pc), 32'h00200);
    check_eq("u2_taken", 32'(taken), 32'd1);
    check_eq("u2_flush", 32'(flush), 32'd1);
    cycle();
    cycle();
    check_eq("u4_ready", 32'(br_ready), 32'd1);

    // PC wrap, then pc_inc coinciding with acceptance
    jump(20'hFFFFF);
    pc_inc = 1'b1;
    cycle();
    check_eq("pc_wrap", 32'(pc), 32'h0);
    br_valid = 1'b1; br_cond = 3'b101; br_target = 20'h00777;
    cycle();  // accept with pc_inc high
    br_valid = 1'b0;
    check_eq("inc_ignored", 32'(pc), 32'h0);
    cycle();
    pc_inc = 1'b0;
    check_eq("never_pc", 32'(pc), 32'h1);
    check_eq("never_taken", 32'(taken), 32'd0);

    // Reset during flush
    br_valid = 1'b1; br_cond = 3'b000; br_target = 20'h00345;
    cycle();
    br_valid = 1'b0;
    cycle();
    check_eq("pre_rst_flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_flush", 32'(flush), 32'd0);
    check_eq("mid_rst_taken", 32'(taken), 32'd0);
    check_eq("mid_rst_pc", 32'(pc), 32'h0);
    check_eq("mid_rst_ready", 32'(br_ready), 32'd0);
    check_eq("mid_rst_zf", 32'(zf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_eq("post_rst_ready", 32'(br_ready), 32'd1);
    check_eq("post_rst_flush", 32'(flush), 32'd0);
    jump(20'h00042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
